// File: rtl/byte_serial_divider.sv
// byte_serial_divider
// Byte-serial integer divider. It takes a dividend and then a divisor over an
// 8-bit push port, MSB byte first. It runs a radix-2 non-restoring division
// that produces one quotient bit per cycle. It then streams the remainder
// followed by the quotient, each LSB byte first, under a valid/ready handshake.
// Signed mode divides the operand magnitudes and fixes the signs afterwards.
// This gives a quotient truncated toward zero and a remainder that carries
// the dividend's sign.

module byte_serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] data_in,
  input  logic       sign,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       sign_out,
  output logic       div_zero,
  output logic       busy
);

  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(2 * NB);
  localparam int IW = $clog2(WIDTH);

  localparam logic [CW-1:0]    BYTE_LAST = CW'(2 * NB - 1);
  localparam logic [CW-1:0]    BYTE_PREV = CW'(2 * NB - 2);
  localparam logic [CW-1:0]    DVD_BYTES = CW'(NB);
  localparam logic [IW-1:0]    ITER_LAST = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;

  // Byte counter: operand bytes while loading, result bytes while emitting.
  logic [CW-1:0] cnt;
  logic [IW-1:0] iter;

  // Raw operands exactly as received. The dividend copy is kept intact for
  // the divide-by-zero remainder.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  // Datapath: divisor magnitude, quotient/shift register, partial remainder.
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;

  // Sign fix-up flags, captured when the operation starts.
  logic qneg;
  logic rneg;
  logic ovf;

  // Result bytes waiting to go out. The low byte mirrors data_out.
  logic [2*WIDTH-1:0] obuf;

  // Combinational helpers.
  logic             accept;
  logic [WIDTH-1:0] divisor_full;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             is_zero;
  logic             is_ovf;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // in_ready is registered and is high only in LOAD.
  // Because of that, a push while it is low is simply ignored.
  assign accept = push & in_ready;

  // Operand assembly and magnitude extraction, used on the final-byte edge.
  // NOTE: every always_comb output gets a value on every path (defaults first), so no latch is inferred.
  always_comb begin
    divisor_full = (dvs << 8) | WIDTH'(data_in);
    dvd_neg      = sign & dvd[WIDTH-1];
    dvs_neg      = sign & divisor_full[WIDTH-1];
    dvd_mag      = dvd_neg ? -dvd : dvd;
    dvs_mag      = dvs_neg ? -divisor_full : divisor_full;
    is_zero      = (divisor_full == '0);
    is_ovf       = sign && (dvd == MIN_VAL) && (divisor_full == '1);
  end

  // One non-restoring step.
  // The quotient register doubles as the source of dividend bits.
  // The sign of the partial remainder picks add or subtract.
  always_comb begin
    d_ext   = {1'b0, dmag};
    r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
    r_step  = r[WIDTH] ? (r_shift + d_ext) : (r_shift - d_ext);
    q_step  = {q[WIDTH-2:0], ~r_step[WIDTH]};
  end

  // Final correction, sign restoration and the two special cases.
  // A negative remainder plus the divisor always lands in [0, divisor).
  // So only the low WIDTH bits of that sum are needed.
  always_comb begin
    r_mag = r[WIDTH] ? (r[WIDTH-1:0] + dmag) : r[WIDTH-1:0];
    q_fix = qneg ? -q : q;
    r_fix = rneg ? -r_mag : r_mag;
    if (div_zero) begin
      q_fix = '1;
      r_fix = dvd;
    end else if (ovf) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
  end

  // Control FSM and datapath registers.
  // Every output is registered; reset abandons any operation in flight.
  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      iter      <= '0;
      dvd       <= '0;
      dvs       <= '0;
      dmag      <= '0;
      q         <= '0;
      r         <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      ovf       <= 1'b0;
      obuf      <= '0;
      in_ready  <= 1'b1;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sign_out  <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            // The first NB bytes build the dividend; the rest build the divisor.
            if (cnt < DVD_BYTES) begin
              dvd <= (dvd << 8) | WIDTH'(data_in);
            end else begin
              dvs <= divisor_full;
            end
            cnt <= cnt + 1'b1;
            if (cnt == BYTE_LAST) begin
              cnt      <= '0;
              iter     <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              sign_out <= sign;
              q        <= dvd_mag;
              dmag     <= dvs_mag;
              r        <= '0;
              qneg     <= dvd_neg ^ dvs_neg;
              rneg     <= dvd_neg;
              ovf      <= is_ovf;
              div_zero <= is_zero;
              // Nothing to iterate on a zero divisor; go straight to the fix-up.
              state    <= is_zero ? FIX : CALC;
            end
          end
        end

        CALC: begin
          r    <= r_step;
          q    <= q_step;
          iter <= iter + 1'b1;
          if (iter == ITER_LAST) begin
            state <= FIX;
          end
        end

        FIX: begin
          obuf      <= {q_fix, r_fix};
          data_out  <= r_fix[7:0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          cnt       <= '0;
          state     <= OUT;
        end

        OUT: begin
          // out_valid is always high here; a transfer needs only out_ready.
          if (out_ready) begin
            if (out_last) begin
              state     <= LOAD;
              cnt       <= '0;
              obuf      <= '0;
              data_out  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              div_zero  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              obuf     <= obuf >> 8;
              data_out <= obuf[15:8];
              out_last <= (cnt == BYTE_PREV);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_divider.sv
// Self-checking bench for byte_serial_divider.
// It runs directed cases (unsigned, signed, divide-by-zero, signed overflow,
// back-pressure, reset mid-CALC, and a 16-bit instance), then a randomised
// batch. The random batch is compared against an arithmetic reference model.

module tb_byte_serial_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       push;
  logic [7:0] data_in;
  logic       sign;
  logic       in_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       sign_out;
  logic       div_zero;
  logic       busy;

  logic       push16;
  logic [7:0] data_in16;
  logic       sign16;
  logic       in_ready16;
  logic [7:0] data_out16;
  logic       out_valid16;
  logic       out_ready16;
  logic       out_last16;
  logic       sign_out16;
  logic       div_zero16;
  logic       busy16;

  int checks = 0;
  int errors = 0;

  byte_serial_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .sign(sign),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .sign_out(sign_out),
    .div_zero(div_zero), .busy(busy)
  );

  byte_serial_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .push(push16), .data_in(data_in16), .sign(sign16),
    .in_ready(in_ready16), .data_out(data_out16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_last(out_last16), .sign_out(sign_out16),
    .div_zero(div_zero16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain language-level division with the documented special cases.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Push dividend then divisor, MSB byte first, with optional idle gaps.
  // Sign is only meaningful with the last byte, so other bytes carry noise.
  // Returns at the falling edge just after the accepting edge E.
  task automatic load_operands(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input int gap_max);
    logic [63:0] word;
    int gap;
    word = {a, b};
    for (int i = 0; i < 8; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      push = 1'b0;
      repeat (gap) @(negedge clk);
      push    = 1'b1;
      data_in = word[63 - 8*i -: 8];
      sign    = (i == 7) ? s : 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    push = 1'b0;
  endtask

  // bp_mode: 0 = always ready, 1 = random ready, 2 = stall 3 cycles after byte 3.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input int gap_max, input int bp_mode);
    int j;
    int n;
    int stalls;
    int guard;
    logic was_stalled;
    logic [7:0] held;
    logic [63:0] got;
    logic [7:0] lastv;
    logic [7:0] dzv;
    logic [7:0] sov;

    out_ready = 1'b0;
    load_operands(a, b, s, gap_max);
    check({tag, "_busy"}, {62'd0, busy, in_ready}, 64'd2);

    // out_valid is first visible after edge E+j; the consumer samples it at E+j+1.
    j = 0;
    while (!out_valid && j < 200) begin
      @(negedge clk);
      j++;
    end
    check({tag, "_latency"}, 64'(j + 1), (b == 32'd0) ? 64'd2 : 64'd34);

    n = 0;
    stalls = 0;
    guard = 0;
    was_stalled = 1'b0;
    held = '0;
    got = '0;
    lastv = '0;
    dzv = '0;
    sov = '0;
    while (n < 8 && guard < 300) begin
      if (was_stalled) check({tag, "_hold"}, {56'd0, data_out}, {56'd0, held});
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          out_ready = !(n == 3 && stalls < 3);
          if (n == 3 && stalls < 3) stalls++;
        end
      endcase
      // Pushes during output must be ignored.
      push    = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in = 8'($urandom);
      if (out_valid && out_ready) begin
        got[8*n +: 8] = data_out;
        lastv[n] = out_last;
        dzv[n]   = div_zero;
        sov[n]   = sign_out;
        n++;
        was_stalled = 1'b0;
      end else if (out_valid) begin
        was_stalled = 1'b1;
        held = data_out;
      end
      @(negedge clk);
      guard++;
    end
    push = 1'b0;
    out_ready = 1'b0;

    check({tag, "_nbytes"}, 64'(n), 64'd8);
    check({tag, "_idle"}, {61'd0, in_ready, out_valid, busy}, 64'd4);
    check({tag, "_rem"}, {32'd0, got[31:0]}, {32'd0, exp_r});
    check({tag, "_quo"}, {32'd0, got[63:32]}, {32'd0, exp_q});
    check({tag, "_last"}, {56'd0, lastv}, 64'h80);
    check({tag, "_dz"}, {56'd0, dzv}, (b == 32'd0) ? 64'hFF : 64'h00);
    check({tag, "_sign"}, {56'd0, sov}, s ? 64'hFF : 64'h00);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        s;
    logic [31:0] got16;
    logic [3:0]  last16;
    int n16;
    int guard16;

    rst = 1'b1;
    push = 1'b0;
    data_in = '0;
    sign = 1'b0;
    out_ready = 1'b0;
    push16 = 1'b0;
    data_in16 = '0;
    sign16 = 1'b0;
    out_ready16 = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_hold", {50'd0, in_ready, out_valid, out_last, sign_out, div_zero, busy, data_out},
          {50'd0, 1'b1, 5'b0, 8'h00});
    rst = 1'b0;
    @(negedge clk);
    check("reset_rel", {50'd0, in_ready, out_valid, out_last, sign_out, div_zero, busy, data_out},
          {50'd0, 1'b1, 5'b0, 8'h00});
    check("reset16", {56'd0, in_ready16, out_valid16, busy16, div_zero16, 4'd0}, {56'd0, 8'h80});

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, 0);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 0);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0, 0);
    run_op("dz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0, 0);
    run_op("bp", 32'hDEAD_BEEF, 32'd1234, 1'b0, 32'hDEAD_BEEF / 32'd1234,
           32'hDEAD_BEEF % 32'd1234, 0, 2);

    // Reset in the middle of CALC discards the operation.
    load_operands(32'd555, 32'd5, 1'b0, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_calc", {50'd0, in_ready, out_valid, out_last, sign_out, div_zero, busy, data_out},
          {50'd0, 1'b1, 5'b0, 8'h00});
    rst = 1'b0;
    @(negedge clk);
    check("rst_calc_rel", {50'd0, in_ready, out_valid, out_last, sign_out, div_zero, busy, data_out},
          {50'd0, 1'b1, 5'b0, 8'h00});
    run_op("after_rst", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 0, 0);

    // Randomised batch against the reference model.
    for (int t = 0; t < 24; t++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        2:       b = -32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, mq, mr);
      run_op($sformatf("rnd%0d", t), a, b, s, mq, mr, 2, int'($urandom_range(0, 1)));
    end

    // 16-bit instance: 0xFFFF / 3 unsigned.
    for (int i = 0; i < 4; i++) begin
      push16 = 1'b1;
      data_in16 = (i == 3) ? 8'h03 : ((i == 2) ? 8'h00 : 8'hFF);
      sign16 = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    push16 = 1'b0;
    out_ready16 = 1'b1;
    got16 = '0;
    last16 = '0;
    n16 = 0;
    guard16 = 0;
    while (n16 < 4 && guard16 < 100) begin
      if (out_valid16) begin
        got16[8*n16 +: 8] = data_out16;
        last16[n16] = out_last16;
        n16++;
      end
      @(negedge clk);
      guard16++;
    end
    out_ready16 = 1'b0;
    check("w16_bytes", {32'd0, got16}, 64'h5555_0000);
    check("w16_last", {60'd0, last16}, 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
